// File: rtl/rv_core_pkg.sv
// Shared core types for the writeback path: data/address widths, the writeback
// request record and the register-file write-port arbiter states.
package rv_core_pkg;

    localparam int XLEN       = 32;
    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = $clog2(NREGS);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_HELD,
        ARB_FORCE
    } wb_arb_state_t;

endpackage

// File: rtl/rf_busy_scoreboard.sv
// Busy-register vector for in-flight MUL/DIV destinations. Flush clears all bits,
// a same-cycle set beats a clear, and x0 is never marked busy.
module rf_busy_scoreboard #(
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             set_en,
    input  logic [AW-1:0]    set_idx,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_idx,
    output logic [NREGS-1:0] busy
);

    logic [NREGS-1:0] busy_nxt;

    always_comb begin
        busy_nxt = busy;
        if (clr_en) busy_nxt[clr_idx] = 1'b0;
        if (set_en) busy_nxt[set_idx] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, one buffered
// MUL/DIV result is forced through after MAX_WAIT lost cycles.
module rf_wb_arbiter
    import rv_core_pkg::wb_arb_state_t, rv_core_pkg::ARB_IDLE,
           rv_core_pkg::ARB_HELD, rv_core_pkg::ARB_FORCE;
#(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     pipe_valid,
    input  logic [$clog2(NREGS)-1:0] pipe_rd,
    input  logic [XLEN-1:0]          pipe_wdata,
    output logic                     pipe_ready,
    input  logic                     md_issue,
    input  logic [$clog2(NREGS)-1:0] md_issue_rd,
    input  logic                     md_valid,
    input  logic [$clog2(NREGS)-1:0] md_rd,
    input  logic [XLEN-1:0]          md_wdata,
    output logic                     md_ready,
    output logic                     rf_we,
    output logic [$clog2(NREGS)-1:0] rf_rd_addr,
    output logic [XLEN-1:0]          rf_wdata,
    output logic [NREGS-1:0]         busy,
    output logic                     force_md
);

    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(MAX_WAIT + 1);

    wb_arb_state_t   state, state_nxt;
    logic [CW-1:0]   wait_cnt, wait_nxt;
    logic [AW-1:0]   hold_rd;
    logic [XLEN-1:0] hold_data;
    logic            hold_v, pipe_wr, pipe_grant, hold_grant, hold_drop, load_hold;

    assign hold_v  = (state != ARB_IDLE);
    assign pipe_wr = pipe_valid && (pipe_rd != '0);

    always_comb begin
        pipe_grant = 1'b0;
        hold_grant = 1'b0;
        pipe_ready = 1'b1;
        if (state == ARB_FORCE) begin
            hold_grant = 1'b1;
            pipe_ready = 1'b0;
        end else if (pipe_wr) begin
            pipe_grant = 1'b1;
        end else begin
            hold_grant = hold_v;
        end
    end

    // A pipe write to the held destination is younger, so the held result is dead.
    assign hold_drop = pipe_grant && hold_v && (pipe_rd == hold_rd);
    assign md_ready  = !hold_v || hold_grant;
    assign load_hold = md_valid && md_ready && !flush && (md_rd != '0);
    assign force_md  = (state == ARB_FORCE);

    always_comb begin
        rf_we      = 1'b0;
        rf_rd_addr = '0;
        rf_wdata   = '0;
        if (pipe_grant) begin
            rf_we      = 1'b1;
            rf_rd_addr = pipe_rd;
            rf_wdata   = pipe_wdata;
        end else if (hold_grant) begin
            rf_we      = 1'b1;
            rf_rd_addr = hold_rd;
            rf_wdata   = hold_data;
        end
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        if (flush) begin
            state_nxt = ARB_IDLE;
            wait_nxt  = '0;
        end else if (!hold_v || hold_grant || hold_drop) begin
            state_nxt = load_hold ? ARB_HELD : ARB_IDLE;
            wait_nxt  = '0;
        end else begin
            wait_nxt  = wait_cnt + CW'(1);
            state_nxt = (wait_nxt == CW'(MAX_WAIT)) ? ARB_FORCE : ARB_HELD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Payload is qualified by state, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load_hold) begin
            hold_rd   <= md_rd;
            hold_data <= md_wdata;
        end
    end

    rf_busy_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_busy (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .set_en  (md_issue && (md_issue_rd != '0)),
        .set_idx (md_issue_rd),
        .clr_en  (hold_grant || hold_drop),
        .clr_idx (hold_rd),
        .busy    (busy)
    );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: directed scenarios plus random traffic checked
// against a transaction-level model of the write-port sharing rules.
module tb_rf_wb_arbiter;

    localparam int XLEN     = 32;
    localparam int NREGS    = 32;
    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        pipe_valid = 1'b0;
    logic [4:0]  pipe_rd = '0;
    logic [31:0] pipe_wdata = '0;
    logic        pipe_ready;
    logic        md_issue = 1'b0;
    logic [4:0]  md_issue_rd = '0;
    logic        md_valid = 1'b0;
    logic [4:0]  md_rd = '0;
    logic [31:0] md_wdata = '0;
    logic        md_ready;
    logic        rf_we;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_wdata;
    logic [31:0] busy;
    logic        force_md;

    rf_wb_arbiter #(.XLEN(XLEN), .NREGS(NREGS), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_wdata(pipe_wdata),
        .pipe_ready(pipe_ready),
        .md_issue(md_issue), .md_issue_rd(md_issue_rd),
        .md_valid(md_valid), .md_rd(md_rd), .md_wdata(md_wdata), .md_ready(md_ready),
        .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_wdata(rf_wdata),
        .busy(busy), .force_md(force_md)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        pr;
        logic        mr;
        logic        fm;
        logic [31:0] busy;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    // Reference model: the pending md result, how many writes it has lost, and the
    // set of registers with an md result still outstanding.
    bit        m_hv;
    bit [4:0]  m_rd;
    bit [31:0] m_data;
    int        m_loss;
    bit [31:0] m_busy;

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h, expected %h", nm, c, act, exp);
        end
    endtask

    task automatic model_clear();
        m_hv = 0; m_rd = 0; m_data = 0; m_loss = 0; m_busy = 0;
    endtask

    task automatic step(input bit pv, input bit [4:0] prd, input bit [31:0] pd,
                        input bit mi, input bit [4:0] mird,
                        input bit mv, input bit [4:0] mrd, input bit [31:0] md,
                        input bit fl);
        exp_t e;
        bit   forced, hw, pw, drop;
        @(posedge clk);
        #1;
        cyc++;
        pipe_valid = pv; pipe_rd = prd; pipe_wdata = pd;
        md_issue = mi; md_issue_rd = mird;
        md_valid = mv; md_rd = mrd; md_wdata = md; flush = fl;

        forced = m_hv && (m_loss == MAX_WAIT);
        hw = 0; pw = 0; drop = 0;
        if (forced) hw = 1;
        else if (pv && prd != 0) begin
            pw = 1;
            drop = m_hv && (m_rd == prd);
        end else if (m_hv) hw = 1;

        e.cyc  = cyc;
        e.we   = pw | hw;
        e.rd   = pw ? prd : (hw ? m_rd : 5'd0);
        e.data = pw ? pd : (hw ? m_data : 32'd0);
        e.pr   = !forced;
        e.mr   = !m_hv || hw;
        e.fm   = forced;
        e.busy = m_busy;
        q.push_back(e);

        if (fl) model_clear();
        else begin
            if (hw || drop) begin
                m_busy[m_rd] = 0;
                m_hv = 0;
            end else if (m_hv) m_loss++;
            if (mi && mird != 0) m_busy[mird] = 1;
            if (mv && e.mr && mrd != 0) begin
                m_hv = 1; m_rd = mrd; m_data = md; m_loss = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reset is asserted between edges, after the previous cycle has been checked.
    task automatic async_reset();
        @(negedge clk);
        #1;
        rst_n = 0;
        pipe_valid = 0; md_valid = 0; md_issue = 0; flush = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("rf_we",      e.cyc, {31'd0, rf_we},      {31'd0, e.we});
            chk("rf_rd_addr", e.cyc, {27'd0, rf_rd_addr}, {27'd0, e.rd});
            chk("rf_wdata",   e.cyc, rf_wdata,            e.data);
            chk("pipe_ready", e.cyc, {31'd0, pipe_ready}, {31'd0, e.pr});
            chk("md_ready",   e.cyc, {31'd0, md_ready},   {31'd0, e.mr});
            chk("force_md",   e.cyc, {31'd0, force_md},   {31'd0, e.fm});
            chk("busy",       e.cyc, busy,                e.busy);
        end
    end

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #3 rst_n = 1;

        // Hold full mid-run, then reset: all state discarded.
        step(0, 0, 0, 1, 5'd14, 0, 0, 0, 0);
        step(1, 5'd2, 32'h11, 0, 0, 1, 5'd14, 32'h1414, 0);
        async_reset();
        idle(2);

        // Single md op to x5 with an idle pipe.
        step(0, 0, 0, 1, 5'd5, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 5'd5, 32'hDEAD_BEEF, 0);
        idle(3);

        // Starvation bound: pipe to x3 every cycle against a held x20 result.
        step(0, 0, 0, 1, 5'd20, 0, 0, 0, 0);
        step(1, 5'd3, 32'h300, 0, 0, 1, 5'd20, 32'h2020_2020, 0);
        for (int i = 1; i <= 7; i++) step(1, 5'd3, 32'h300 + i, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Pipe retiring to x0 lets the hold drain and refill in one cycle.
        step(1, 5'd3, 32'h1, 1, 5'd7, 1, 5'd7, 32'h7777, 0);
        step(1, 5'd0, 32'hBAD, 1, 5'd8, 1, 5'd8, 32'h8888, 0);
        idle(2);

        // Younger pipe write to the held destination drops the hold.
        step(0, 0, 0, 1, 5'd9, 0, 0, 0, 0);
        step(1, 5'd4, 32'h4, 0, 0, 1, 5'd9, 32'h9999, 0);
        step(1, 5'd9, 32'h1, 0, 0, 0, 0, 0, 0);
        idle(3);

        // Flush with hold full: same-cycle grant commits, md handshake discarded.
        step(0, 0, 0, 1, 5'd12, 0, 0, 0, 0);
        step(1, 5'd3, 32'h33, 1, 5'd13, 1, 5'd12, 32'hC0C0, 0);
        step(0, 0, 0, 1, 5'd15, 1, 5'd12, 32'hC1C1, 1);
        idle(3);

        // md result to x0: accepted, never written.
        step(0, 0, 0, 0, 0, 1, 5'd0, 32'hFFFF, 0);
        idle(2);

        // Random traffic over a small register range to provoke collisions.
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 699) async_reset();
            step($urandom_range(0, 99) < 60, 5'($urandom_range(0, 3)), $urandom,
                 $urandom_range(0, 99) < 30, 5'($urandom_range(0, 4)),
                 $urandom_range(0, 99) < 40, 5'($urandom_range(0, 4)), $urandom,
                 $urandom_range(0, 99) < 3);
        end
        idle(2);

        repeat (3) @(negedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
